// File: rtl/vmask_cpop_seq_if.sv
// rtl/vmask_cpop_seq_if.sv - bus bundle for the mask popcount sequencer
// Purpose: groups the request, mask read port, popcount pipeline and response
// signals of vmask_cpop_seq.
// Ports (slave = sequencer side):
//   req_valid/req_ready/req_vl/req_base     request handshake
//   rd_en/rd_addr/rd_data                    mask register read port
//   pop_m0/pop_valid/pop_count/pop_sum       popcount pipeline lanes
//   resp_valid/resp_ready/resp_count         response handshake
//   busy                                     sequencer not idle
interface vmask_cpop_seq_if #(
    parameter int VL_WIDTH   = 11,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [VL_WIDTH-1:0]   req_vl;
    logic [ADDR_WIDTH-1:0] req_base;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic [7:0]            pop_m0;
    logic                  pop_valid;
    logic [RESP_WIDTH-1:0] pop_count;
    logic [7:0]            pop_sum;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [RESP_WIDTH-1:0] resp_count;
    logic                  busy;

    modport slave (
        input  req_valid, req_vl, req_base, rd_data, pop_sum, resp_ready,
        output req_ready, rd_en, rd_addr, pop_m0, pop_valid, pop_count,
               resp_valid, resp_count, busy
    );

    modport master (
        output req_valid, req_vl, req_base, rd_data, pop_sum, resp_ready,
        input  req_ready, rd_en, rd_addr, pop_m0, pop_valid, pop_count,
               resp_valid, resp_count, busy
    );
endinterface

// File: rtl/vmask_cpop_seq.sv
// rtl/vmask_cpop_seq.sv - sequencer streaming mask bytes through a popcount pipeline
// Purpose: on a request (vl, base) reads ceil(vl/8) mask bytes, feeds them with
// tail bits zeroed to the popcount pipeline, sums the pipeline results and
// returns the total over a valid/ready response.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   vmask_cpop_seq_if.slave (request, read port, pipeline, response, busy)
module vmask_cpop_seq #(
    parameter int VL_WIDTH   = 11,
    parameter int ADDR_WIDTH = 8,
    parameter int PIPE_LAT   = 3,
    parameter int RESP_WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    vmask_cpop_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [VL_WIDTH-1:0]   vl_q;
    logic [VL_WIDTH-1:0]   bit_pos;      // mask bit index of the byte being read
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [PIPE_LAT:0]     inflight;     // [0] = issue cycle, [PIPE_LAT] = result cycle
    logic                  last_q;       // byte now on pop_m0 is the final one
    logic [RESP_WIDTH-1:0] acc, acc_nx, resp_count_q;
    logic [VL_WIDTH:0]     pos_next;     // one extra bit so the compare cannot wrap
    logic                  issue_last;
    logic                  accept;
    logic                  rd_en;
    logic [7:0]            tailmask;

    assign rd_en      = (state == ISSUE);
    assign accept     = (state == IDLE) && bus.req_valid;
    assign pos_next   = {1'b0, bit_pos} + (VL_WIDTH + 1)'(8);
    assign issue_last = (pos_next >= {1'b0, vl_q});
    assign acc_nx     = inflight[PIPE_LAT] ? acc + RESP_WIDTH'(bus.pop_sum) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = (bus.req_vl == '0) ? DONE : ISSUE;
            ISSUE:   if (issue_last) state_nx = DRAIN;
            // Only the result tap may still be set; its add lands on this edge.
            DRAIN:   if (inflight[PIPE_LAT-1:0] == '0) state_nx = DONE;
            DONE:    if (bus.resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vl_q         <= '0;
            bit_pos      <= '0;
            rd_addr_q    <= '0;
            inflight     <= '0;
            last_q       <= 1'b0;
            acc          <= '0;
            resp_count_q <= '0;
        end else begin
            inflight <= {inflight[PIPE_LAT-1:0], rd_en};
            last_q   <= rd_en && issue_last;
            acc      <= acc_nx;
            if (accept) begin
                vl_q      <= bus.req_vl;
                bit_pos   <= '0;
                rd_addr_q <= bus.req_base;
                acc       <= '0;
            end else if (rd_en) begin
                bit_pos   <= pos_next[VL_WIDTH-1:0];
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
            end
            // Capture the final sum on DONE entry so it survives the next accept.
            if (state_nx == DONE && state != DONE) begin
                resp_count_q <= accept ? '0 : acc_nx;
            end
        end
    end

    // The pipeline has no valid input, so it must see zero when idle.
    assign tailmask = (last_q && vl_q[2:0] != 3'd0) ? ~(8'hFF << vl_q[2:0]) : 8'hFF;

    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.pop_valid  = inflight[0];
    assign bus.pop_m0     = inflight[0] ? (bus.rd_data & tailmask) : 8'h00;
    assign bus.pop_count  = '0;
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_count = resp_count_q;
    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_vmask_cpop_seq.sv
// tb/tb_vmask_cpop_seq.sv - self-checking bench for vmask_cpop_seq
module tb_vmask_cpop_seq;
    localparam int VLW = 11;
    localparam int AW  = 8;
    localparam int RW  = 64;
    localparam int PL  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vmask_cpop_seq_if #(.VL_WIDTH(VLW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();

    vmask_cpop_seq #(.VL_WIDTH(VLW), .ADDR_WIDTH(AW), .PIPE_LAT(PL), .RESP_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] mem [256];
    logic [7:0] pipe_q [PL];

    // Mask register: data one cycle after rd_en, X otherwise.
    // Popcount pipeline: PL-cycle delayed popcount of pop_m0.
    always @(posedge clk) begin
        bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : 8'hxx;
        pipe_q[0] <= bus.pop_m0;
        for (int i = 1; i < PL; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign bus.pop_sum = 8'($countones(pipe_q[PL-1]));

    int         rd_cnt, pv_cnt, idle_nz;
    logic [7:0] addr_q [$];
    logic [7:0] last_pm0;

    always @(negedge clk) begin
        if (bus.rd_en) begin
            rd_cnt++;
            addr_q.push_back(bus.rd_addr);
        end
        if (bus.pop_valid) begin
            pv_cnt++;
            last_pm0 = bus.pop_m0;
        end else if (bus.pop_m0 !== 8'h00) begin
            idle_nz++;
        end
    end

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int ref_count(input int vl, input int base);
        int c = 0;
        for (int i = 0; i < vl; i++) c += int'(mem[8'(base + i / 8)][i % 8]);
        return c;
    endfunction

    function automatic logic [7:0] ref_last(input int vl, input int base);
        int         n = (vl + 7) / 8;
        logic [7:0] b = 8'h00;
        for (int j = 0; j < 8; j++)
            if ((n - 1) * 8 + j < vl) b[j] = mem[8'(base + n - 1)][j];
        return b;
    endfunction

    task automatic run_req(input int vl, input int base, input int hold, input bit pend);
        int n, k, exp_cnt;
        bit ok;
        n = (vl + 7) / 8;
        exp_cnt = ref_count(vl, base);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_vl    = VLW'(vl);
        bus.req_base  = AW'(base);
        k = 0;
        while (!bus.req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rd_cnt = 0;
        pv_cnt = 0;
        idle_nz = 0;
        addr_q.delete();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.resp_valid && k < 3000);
        check("latency", 64'(k), 64'((vl == 0) ? 1 : n + PL + 2));
        check("resp_count", bus.resp_count, 64'(exp_cnt));
        check("rd_cnt", 64'(rd_cnt), 64'(n));
        check("pv_cnt", 64'(pv_cnt), 64'(n));
        ok = (addr_q.size() == n);
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] !== 8'(base + i)) ok = 1'b0;
        check("rd_addr_seq", 64'(ok), 64'(1));
        check("idle_pop_m0_zero", 64'(idle_nz), 64'(0));
        if (n > 0) check("last_pop_m0", 64'(last_pm0), 64'(ref_last(vl, base)));

        if (pend) begin
            bus.req_valid = 1'b1;
            bus.req_vl    = '0;
            bus.req_base  = '0;
        end
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(bus.resp_valid), 64'(1));
            check("hold_count", bus.resp_count, 64'(exp_cnt));
            check("hold_req_ready", 64'(bus.req_ready), 64'(0));
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 64'(bus.resp_valid), 64'(0));
        check("post_req_ready", 64'(bus.req_ready), 64'(1));
        check("post_busy", 64'(bus.busy), 64'(0));
        check("post_count_held", bus.resp_count, 64'(exp_cnt));
        if (pend) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            check("pend_valid", 64'(bus.resp_valid), 64'(1));
            check("pend_count", bus.resp_count, 64'(0));
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(bus.rd_en), 64'(0));
        check({tag, "_pop_valid"}, 64'(bus.pop_valid), 64'(0));
        check({tag, "_pop_m0"}, 64'(bus.pop_m0), 64'(0));
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(0));
        check({tag, "_resp_count"}, bus.resp_count, 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        check({tag, "_pop_count"}, bus.pop_count, 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_vl     = '0;
        bus.req_base   = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        mem[8'h10] = 8'hFF;
        run_req(8, 'h10, 0, 1'b0);

        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF;
        run_req(20, 0, 0, 1'b0);

        run_req(0, 0, 0, 1'b0);

        mem[0] = 8'hA5; mem[1] = 8'h3C;
        run_req(16, 0, 5, 1'b1);

        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h80; mem[8'h00] = 8'hF0;
        run_req(24, 'hFE, 0, 1'b0);

        for (int i = 0; i < 8; i++) mem[8'h40 + i] = 8'hFF;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_vl    = VLW'(64);
        bus.req_base  = AW'(8'h40);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_issue", 64'(bus.rd_en), 64'(1));
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release_req_ready", 64'(bus.req_ready), 64'(1));
        mem[8'h40] = 8'h0F;
        run_req(8, 'h40, 0, 1'b0);

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        run_req(2047, int'($urandom_range(0, 255)), 1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            run_req(int'($urandom_range(0, 300)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
